// File: rtl/hcsr04_if.sv
// Signal bundle between the ranging controller and its strobe/sensor/result neighbours.
// The controller sits on the slave side: it takes measure/echo and drives trig and the result.
interface hcsr04_if #(
  parameter int CNT_W = 16
);
  logic             measure;
  logic             echo;
  logic             trig;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] echo_us;
  logic [CNT_W-1:0] dist_cm;
  logic             timeout;

  modport master (
    output measure, echo,
    input  trig, busy, valid, echo_us, dist_cm, timeout
  );

  modport slave (
    input  measure, echo,
    output trig, busy, valid, echo_us, dist_cm, timeout
  );
endinterface

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ranging controller: issues the trigger pulse, times the echo in 1 us clocks
// and converts it to centimetres with a running sub-counter instead of a divider.
module hcsr04_ranger #(
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int CM_DIV     = 58,
  parameter int CNT_W      = 16
) (
  input  logic     clk,
  input  logic     rst,
  hcsr04_if.slave  bus
);
  localparam int TW = (TRIG_US > 1) ? $clog2(TRIG_US) : 1;
  localparam logic [TW-1:0]    TRIG_LAST = TW'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] SUB_LAST  = CNT_W'(CM_DIV - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE} state_t;

  state_t           state, next_state;
  logic [2:0]       sync;
  logic             echo_s, echo_d, rise;
  logic [TW-1:0]    trig_cnt;
  logic [CNT_W-1:0] tmo_cnt, echo_cnt, sub_cnt, cm_cnt;
  logic             count_en, tmo_hit, tmo_exit;
  logic             trig_q, valid_q, timeout_q;
  logic [CNT_W-1:0] echo_us_q, dist_cm_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // sync[1] is echo_s, sync[2] its one-cycle-late copy for edge detection
  assign echo_s  = sync[1];
  assign echo_d  = sync[2];
  assign rise    = echo_s & ~echo_d;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    count_en   = 1'b0;
    tmo_exit   = 1'b0;
    case (state)
      IDLE:      if (bus.measure) next_state = TRIG;
      TRIG:      if (trig_cnt == TRIG_LAST) next_state = WAIT_RISE;
      WAIT_RISE: begin
        if (tmo_hit) begin
          next_state = DONE;
          tmo_exit   = 1'b1;
        end else if (rise) begin
          next_state = MEASURE;
          count_en   = 1'b1;
        end
      end
      MEASURE: begin
        // timeout takes priority over an echo fall in the same cycle
        if (tmo_hit) begin
          next_state = DONE;
          tmo_exit   = 1'b1;
        end else if (echo_s) begin
          count_en   = 1'b1;
        end else begin
          next_state = DONE;
        end
      end
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      trig_cnt <= '0;
      tmo_cnt  <= '0;
      echo_cnt <= '0;
      sub_cnt  <= '0;
      cm_cnt   <= '0;
    end else begin
      sync     <= {sync[1:0], bus.echo};
      trig_cnt <= (state == TRIG) ? trig_cnt + 1'b1 : '0;
      if (state == TRIG) begin
        tmo_cnt  <= '0;
        echo_cnt <= '0;
        sub_cnt  <= '0;
        cm_cnt   <= '0;
      end else begin
        if (state == WAIT_RISE || state == MEASURE) tmo_cnt <= sat_inc(tmo_cnt);
        if (count_en) begin
          echo_cnt <= sat_inc(echo_cnt);
          if (sub_cnt == SUB_LAST) begin
            sub_cnt <= '0;
            cm_cnt  <= sat_inc(cm_cnt);
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Outputs are loaded on the edge entering DONE so they line up with valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      echo_us_q <= '0;
      dist_cm_q <= '0;
    end else begin
      trig_q  <= (next_state == TRIG);
      valid_q <= (next_state == DONE);
      if (next_state == DONE) begin
        timeout_q <= tmo_exit;
        echo_us_q <= tmo_exit ? '0 : echo_cnt;
        dist_cm_q <= tmo_exit ? '0 : cm_cnt;
      end
    end
  end

  assign bus.trig    = trig_q;
  assign bus.busy    = (state != IDLE);
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.echo_us = echo_us_q;
  assign bus.dist_cm = dist_cm_q;
endmodule

// File: tb/tb_hcsr04_ranger.sv
// Bench for hcsr04_ranger: drives echo pulses at cycle offsets from the trigger fall and
// compares valid timing and results against an arithmetic model of the ranging rules.
module tb_hcsr04_ranger;
  localparam int TRIG = 10;
  localparam int T    = 2000;
  localparam int DIV  = 58;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  hcsr04_if #(.CNT_W(W)) bus ();

  hcsr04_ranger #(.TRIG_US(TRIG), .TIMEOUT_US(T), .CM_DIV(DIV), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // observations of one measurement
  int         trig_len, vcyc, nval;
  logic [W-1:0] r_us, r_cm;
  logic       r_to, r_busy_after;
  // model expectations
  int         e_cyc, e_us, e_cm;
  logic       e_to;

  // Cycle k = clock cycle k after the trigger falls (k=0 is the first low cycle).
  // Echo driven high in cycles d..d+w-1 is seen synchronized two cycles later; the
  // measurement ends when the synchronized echo is low in cycle d+w+2, valid one later.
  // The timeout counter equals k, so any end at k >= T-1 becomes a timeout valid at k=T.
  task automatic model(input int d, input int w, input bit stale);
    int fall_s;
    fall_s = d + w + 2;
    if (stale || fall_s >= T - 1) begin
      e_cyc = T; e_us = 0; e_cm = 0; e_to = 1'b1;
    end else begin
      e_cyc = fall_s + 1; e_us = w; e_cm = w / DIV; e_to = 1'b0;
    end
  endtask

  task automatic do_measure(input int d, input int w, input bit stale, input bit extra);
    trig_len = 0; vcyc = -1; nval = 0;
    r_us = 'x; r_cm = 'x; r_to = 1'bx; r_busy_after = 1'bx;
    @(negedge clk);
    bus.echo    = stale;
    bus.measure = 1'b1;
    for (int i = 0; i < TRIG + 20; i++) begin
      @(negedge clk);
      if (bus.trig) trig_len++;
      else if (trig_len > 0) break;
      bus.measure = extra && (trig_len == 3);
    end
    bus.measure = 1'b0;
    for (int k = 0; k < T + 40; k++) begin
      if (bus.valid) begin
        nval++;
        if (vcyc < 0) begin
          vcyc = k; r_us = bus.echo_us; r_cm = bus.dist_cm; r_to = bus.timeout;
        end
      end
      if (vcyc >= 0 && k == vcyc + 1) r_busy_after = bus.busy;
      bus.echo    = stale ? 1'b1 : (k >= d && k < d + w);
      bus.measure = extra && (bus.valid || k == d + 4);
      @(negedge clk);
    end
    bus.echo = 1'b0; bus.measure = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.measure = 1'b0; bus.echo = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.trig, bus.busy, bus.valid, bus.timeout, bus.echo_us, bus.dist_cm} !== '0) begin
      bad++;
      $display("FAIL reset_hold outputs got %b want all zero",
               {bus.trig, bus.busy, bus.valid, bus.timeout, bus.echo_us, bus.dist_cm});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.trig, bus.busy, bus.valid, bus.timeout, bus.echo_us, bus.dist_cm} !== '0) begin
      bad++;
      $display("FAIL reset_release outputs got %b want all zero",
               {bus.trig, bus.busy, bus.valid, bus.timeout, bus.echo_us, bus.dist_cm});
    end
  endtask

  task automatic test_basic();
    do_measure(100, 580, 1'b0, 1'b0);
    model(100, 580, 1'b0);
    total++; if (trig_len !== TRIG) begin bad++; $display("FAIL basic trig_len got %0d want %0d", trig_len, TRIG); end
    total++; if (nval !== 1)        begin bad++; $display("FAIL basic nvalid got %0d want 1", nval); end
    total++; if (vcyc !== e_cyc)    begin bad++; $display("FAIL basic valid_cycle got %0d want %0d", vcyc, e_cyc); end
    total++; if (r_us !== W'(580))  begin bad++; $display("FAIL basic echo_us got %0d want 580", r_us); end
    total++; if (r_cm !== W'(10))   begin bad++; $display("FAIL basic dist_cm got %0d want 10", r_cm); end
    total++; if (r_to !== 1'b0)     begin bad++; $display("FAIL basic timeout got %b want 0", r_to); end
  endtask

  // fixed widths around the centimetre boundary, the timeout edge, then random cases
  task automatic test_widths();
    int ds[$];
    int ws[$];
    ds = {30, 0, 250, 100, 100};
    ws = {57, 58, 116, T - 104, T - 103};
    for (int i = 0; i < 8; i++) begin
      ds.push_back(int'($urandom_range(0, 300)));
      ws.push_back(int'($urandom_range(1, 1900)));
    end
    foreach (ds[i]) begin
      do_measure(ds[i], ws[i], 1'b0, 1'b0);
      model(ds[i], ws[i], 1'b0);
      total++; if (nval !== 1)         begin bad++; $display("FAIL width[%0d] nvalid got %0d want 1", i, nval); end
      total++; if (vcyc !== e_cyc)     begin bad++; $display("FAIL width[%0d] valid_cycle got %0d want %0d", i, vcyc, e_cyc); end
      total++; if (r_us !== W'(e_us))  begin bad++; $display("FAIL width[%0d] echo_us got %0d want %0d", i, r_us, e_us); end
      total++; if (r_cm !== W'(e_cm))  begin bad++; $display("FAIL width[%0d] dist_cm got %0d want %0d", i, r_cm, e_cm); end
      total++; if (r_to !== e_to)      begin bad++; $display("FAIL width[%0d] timeout got %b want %b", i, r_to, e_to); end
    end
  endtask

  // no echo at all, then an echo already high before the trigger
  task automatic test_timeout();
    for (int s = 0; s < 2; s++) begin
      do_measure(T + 100, 1, s[0], 1'b0);
      model(T + 100, 1, s[0]);
      total++; if (nval !== 1)           begin bad++; $display("FAIL timeout[%0d] nvalid got %0d want 1", s, nval); end
      total++; if (vcyc !== e_cyc)       begin bad++; $display("FAIL timeout[%0d] valid_cycle got %0d want %0d", s, vcyc, e_cyc); end
      total++; if ({r_us, r_cm} !== '0)  begin bad++; $display("FAIL timeout[%0d] us/cm got %0d/%0d want 0/0", s, r_us, r_cm); end
      total++; if (r_to !== 1'b1)        begin bad++; $display("FAIL timeout[%0d] timeout got %b want 1", s, r_to); end
      total++; if (r_busy_after !== 1'b0) begin bad++; $display("FAIL timeout[%0d] busy_after got %b want 0", s, r_busy_after); end
    end
  endtask

  task automatic test_extra_strobes();
    do_measure(40, 200, 1'b0, 1'b1);
    model(40, 200, 1'b0);
    total++; if (trig_len !== TRIG)     begin bad++; $display("FAIL extra trig_len got %0d want %0d", trig_len, TRIG); end
    total++; if (nval !== 1)            begin bad++; $display("FAIL extra nvalid got %0d want 1", nval); end
    total++; if (vcyc !== e_cyc)        begin bad++; $display("FAIL extra valid_cycle got %0d want %0d", vcyc, e_cyc); end
    total++; if (r_us !== W'(e_us))     begin bad++; $display("FAIL extra echo_us got %0d want %0d", r_us, e_us); end
    total++; if (r_busy_after !== 1'b0) begin bad++; $display("FAIL extra busy_after got %b want 0", r_busy_after); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.measure = 1'b1;
    @(negedge clk);
    bus.measure = 1'b0;
    repeat (TRIG + 2) @(negedge clk);
    bus.echo = 1'b1;
    repeat (30) @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midreset busy_before got %b want 1", bus.busy); end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.trig, bus.busy, bus.valid, bus.timeout, bus.echo_us, bus.dist_cm} !== '0) begin
      bad++;
      $display("FAIL midreset outputs got %b want all zero",
               {bus.trig, bus.busy, bus.valid, bus.timeout, bus.echo_us, bus.dist_cm});
    end
    bus.echo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_measure(20, 290, 1'b0, 1'b0);
    model(20, 290, 1'b0);
    total++; if (vcyc !== e_cyc)    begin bad++; $display("FAIL postreset valid_cycle got %0d want %0d", vcyc, e_cyc); end
    total++; if (r_us !== W'(290))  begin bad++; $display("FAIL postreset echo_us got %0d want 290", r_us); end
    total++; if (r_cm !== W'(5))    begin bad++; $display("FAIL postreset dist_cm got %0d want 5", r_cm); end
    total++; if (r_to !== 1'b0)     begin bad++; $display("FAIL postreset timeout got %b want 0", r_to); end
  endtask

  initial begin
    bus.measure = 1'b0;
    bus.echo    = 1'b0;
    test_reset();
    test_basic();
    test_widths();
    test_timeout();
    test_extra_strobes();
    test_basic();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
